aes_key_expand: RTL and testbench

Parametrised successor of the AES-128 round-by-round key schedule. Supports AES-128, AES-192 and AES-256, selected per operation. Expands a key iteratively, one 32-bit word per cycle, into an internal round-key store. The cipher datapath reads any round key by index through a registered read port once `done` is seen. Reuses four `aes_sbox` instances for SubWord.

---
 rtl/aes_key_expand.sv | 151 +++++++++++++++
 tb/tb_aes_key_expand.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// AES-128/192/256 iterative key schedule: one word per cycle into a 15-entry round-key store.
// Optional AES_KS_RD_MASK_EN zeroes reads while busy or beyond the current key's round count.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign out_o = SBOX[in_i];
endmodule

module aes_key_expand #(
    parameter int KEY_W   = 256,
    parameter int MAX_RND = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic [KEY_W-1:0] ip_key,
    input  logic [3:0]       rd_rnd,
    output logic             busy,
    output logic             done,
    output logic [3:0]       nr,
    output logic [127:0]     rd_key
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

    state_e           state_q;
    logic [3:0][31:0] store_q [MAX_RND+1];
    logic [7:0][31:0] win_q;
    logic [5:0]       i_q;
    logic [2:0]       j_q;
    logic [3:0]       nk_q;
    logic [7:0]       rcon_q;
    logic             busy_q, done_q;
    logic [3:0]       nr_q;
    logic [127:0]     rd_key_q;

    logic [7:0][31:0] kw;
    logic [3:0]       nk_d, nr_d;
    logic [2:0]       old_idx;
    logic [31:0]      prev_w, old_w, sub_in, sub_out, temp, new_w;
    logic             rd_mask;

    assign kw      = ip_key[255:0];
    assign old_idx = 3'(nk_q - 4'd1);
    assign prev_w  = win_q[0];
    assign old_w   = win_q[old_idx];
    assign sub_in  = (j_q == 3'd0) ? {prev_w[7:0], prev_w[31:8]} : prev_w;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.in_i(sub_in[8*g +: 8]), .out_o(sub_out[8*g +: 8]));
    end

    always_comb begin
        nk_d = 4'd4;
        nr_d = 4'd10;
        case (key_len)
            2'd1:    begin nk_d = 4'd6; nr_d = 4'd12; end
            2'd2:    begin nk_d = 4'd8; nr_d = 4'd14; end
            default: begin nk_d = 4'd4; nr_d = 4'd10; end
        endcase
    end

    // j==0 is the RotWord/SubWord/Rcon step; the extra SubWord at j==4 only exists for 256-bit keys
    always_comb begin
        temp = prev_w;
        if (j_q == 3'd0)
            temp = sub_out ^ {24'h0, rcon_q};
        else if (nk_q == 4'd8 && j_q == 3'd4)
            temp = sub_out;
        new_w = old_w ^ temp;
    end

    always_comb begin
`ifdef AES_KS_RD_MASK_EN
        rd_mask = busy_q || (rd_rnd > nr_q) || (nr_q == 4'd0);
`else
        rd_mask = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            nr_q     <= 4'd0;
            rd_key_q <= '0;
            rcon_q   <= 8'h01;
            i_q      <= '0;
            j_q      <= '0;
            nk_q     <= 4'd4;
            win_q    <= '0;
            for (int r = 0; r <= MAX_RND; r++) store_q[r] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= EXPAND;
                    busy_q  <= 1'b1;
                    nk_q    <= nk_d;
                    nr_q    <= nr_d;
                    i_q     <= 6'(nk_d);
                    j_q     <= '0;
                    rcon_q  <= 8'h01;
                    // window[0] holds the newest key word, window[nk-1] the oldest
                    for (int k = 0; k < 8; k++) begin
                        if (k < int'(nk_d)) begin
                            store_q[4'(k / 4)][2'(k % 4)] <= kw[3'(k)];
                            win_q[3'(k)] <= kw[3'(int'(nk_d) - 1 - k)];
                        end
                    end
                end
                EXPAND: begin
                    store_q[i_q[5:2]][i_q[1:0]] <= new_w;
                    win_q <= {win_q[6:0], new_w};
                    i_q   <= i_q + 6'd1;
                    j_q   <= ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
                    if (j_q == 3'd0)
                        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    if (i_q == {nr_q, 2'b11}) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (rd_rnd > 4'(MAX_RND) || rd_mask)
                rd_key_q <= '0;
            else
                rd_key_q <= store_q[rd_rnd];
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign nr     = nr_q;
    assign rd_key = rd_key_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors plus random keys against a byte-level key-schedule model.
module tb_aes_key_expand;
    logic         clk, rst, start;
    logic [1:0]   key_len;
    logic [255:0] ip_key;
    logic [3:0]   rd_rnd;
    logic         busy, done;
    logic [3:0]   nr;
    logic [127:0] rd_key;

    aes_key_expand dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .ip_key(ip_key),
        .rd_rnd(rd_rnd), .busy(busy), .done(done), .nr(nr), .rd_key(rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [7:0]   sb [256];
    logic [127:0] m_store [15];
    int           m_nr = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse by search, then the affine map
    task automatic build_sbox();
        logic [7:0] inv, s, x;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (v != 0 && gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv; x = inv;
            for (int n = 0; n < 4; n++) begin
                x = {x[6:0], x[7]};
                s = s ^ x;
            end
            sb[v] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic model_run(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nrm;
        nrm = nk + 6;
        rc  = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < 4*nrm + 4; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[7:0], t[31:8]});
                t[7:0] = t[7:0] ^ rc;
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nrm; r++) m_store[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
        m_nr = nrm;
    endtask

    function automatic logic [127:0] exp_rd(input int r);
        if (r > 14) return '0;
`ifdef AES_KS_RD_MASK_EN
        if (m_nr == 0 || r > m_nr) return '0;
`endif
        return m_store[r];
    endfunction

    // FIPS hex strings list byte 0 first; the ports put byte 0 in the low bits
    function automatic logic [255:0] fips(input logic [255:0] s, input int nbytes);
        logic [255:0] o;
        o = '0;
        for (int i = 0; i < nbytes; i++) o[8*i +: 8] = s[8*(nbytes-1-i) +: 8];
        return o;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
        return k;
    endfunction

    task automatic rd_chk(input string tag, input int r, input logic [127:0] exp);
        rd_rnd = 4'(r);
        @(negedge clk);
        chk(tag, rd_key, exp);
    endtask

    task automatic rd_all();
        for (int r = 0; r < 16; r++) rd_chk($sformatf("rd_rnd_%0d", r), r, exp_rd(r));
    endtask

    // Starts at the negedge of the accept cycle; pulses an alternate start in cycles ign_a/ign_b
    task automatic run_key(input logic [255:0] key, input int kl, input int ign_a, input int ign_b);
        int nk, n_exp, busy_cnt, done_cyc;
        logic [127:0] r0_exp;
        nk    = (kl == 1) ? 6 : (kl == 2) ? 8 : 4;
        n_exp = 4*(nk + 6) + 4 - nk;
        ip_key = key; key_len = 2'(kl); start = 1'b1; rd_rnd = 4'd0;
        busy_cnt = 0; done_cyc = -1;
`ifdef AES_KS_RD_MASK_EN
        r0_exp = '0;
`else
        r0_exp = key[127:0];
`endif
        for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
            @(negedge clk);
            start   = (c == ign_a || c == ign_b);
            ip_key  = start ? ~key : key;
            key_len = start ? 2'd2 : 2'(kl);
            if (c == 3) chk("rd_during_busy", rd_key, r0_exp);
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = c;
                chk("busy_at_done", {127'd0, busy}, 128'd0);
            end
        end
        @(negedge clk);
        start = 1'b0; ip_key = key; key_len = 2'(kl);
        chk("done_cycle", 128'(done_cyc), 128'(n_exp + 1));
        chk("busy_cycles", 128'(busy_cnt), 128'(n_exp));
        chk("idle_after_done", {126'd0, busy, done}, 128'd0);
        chk("nr", {124'd0, nr}, 128'(nk + 6));
        model_run(key, nk);
    endtask

    logic [255:0] k128, k192, k256, tmp;
    logic [127:0] r10_128, r12_192, r14_256;
    logic         dseen;

    initial begin
        rst = 1'b1; start = 1'b0; key_len = 2'd0; ip_key = '0; rd_rnd = 4'd0;
        build_sbox();
        k128 = fips(256'h2b7e151628aed2a6abf7158809cf4f3c, 16);
        k192 = fips(256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 24);
        k256 = fips(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 32);
        tmp = fips(256'hd014f9a8c9ee2589e13f0cc8b6630ca6, 16); r10_128 = tmp[127:0];
        tmp = fips(256'he98ba06f448c773c8ecc720401002202, 16); r12_192 = tmp[127:0];
        tmp = fips(256'hfe4890d1e6188d0b046df344706c631e, 16); r14_256 = tmp[127:0];

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", {nr, busy, done}, 128'd0);
        chk("reset_rd_key", rd_key, 128'd0);
        rd_chk("reset_store_r14", 14, 128'd0);

        run_key(k128, 0, -1, -1);
        rd_chk("aes128_r10", 10, r10_128);
        rd_chk("aes128_r0", 0, k128[127:0]);
        rd_all();

        // alternate starts in cycles 5 and N+1 must be ignored
        run_key(k128, 0, 5, 41);
        rd_chk("ignored_start_r10", 10, r10_128);

        run_key(k192, 1, -1, -1);
        rd_chk("aes192_r12", 12, r12_192);
        rd_all();

        run_key(k256, 2, -1, -1);
        rd_chk("aes256_r14", 14, r14_256);
        rd_all();

        // reset in cycle 20 of an AES-256 run
        ip_key = k256; key_len = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {nr, busy, done}, 128'd0);
        chk("abort_rd_key", rd_key, 128'd0);
        rst = 1'b0;
        for (int r = 0; r < 15; r++) m_store[r] = '0;
        m_nr = 0;
        dseen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done) dseen = 1'b1;
        end
        chk("no_done_after_abort", {127'd0, dseen}, 128'd0);
        run_key(k128, 0, -1, -1);
        rd_chk("post_abort_r10", 10, r10_128);
        rd_all();

        for (int n = 0; n < 5; n++) begin
            run_key(rand_key(), int'($urandom_range(0, 3)), -1, -1);
            rd_all();
        end

        // key_len=3 after a 256-bit key leaves stale rounds 11..14
        run_key(rand_key(), 2, -1, -1);
        run_key(rand_key(), 3, -1, -1);
        rd_chk("klen3_r15", 15, 128'd0);
        rd_chk("klen3_r11", 11, exp_rd(11));
        rd_chk("klen3_r10", 10, exp_rd(10));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
